adc_trig_capture: RTL

//  Parametrised N-channel ADC waveform capture controller, in the ADC sample-clock domain ahead of the DAT_FIFOs.

---
 rtl/adc_trig_capture.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/adc_trig_capture.sv
// rtl/adc_trig_capture.sv - N-channel ADC capture controller with pre-trigger history and framed record output
`timescale 1ns/1ps
module adc_trig_capture #(
    parameter int NCH   = 2,
    parameter int DW    = 14,
    parameter int DEPTH = 256,
    parameter int LW    = 12,
    parameter int TW    = 40,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] adc_data,
    input  logic              arm,
    input  logic [1:0]        mode,
    input  logic              trig_pulse,
    input  logic              ext_trig,
    input  logic [DW-1:0]     threshold,
    input  logic [LW-1:0]     rec_len,
    input  logic [AW-1:0]     pre_len,
    input  logic [15:0]       holdoff,
    input  logic              fifo_full,
    input  logic              clr_ovf,
    output logic              wr_en,
    output logic [NCH*DW-1:0] wr_data,
    output logic              wr_sof,
    output logic              wr_eof,
    output logic              busy,
    output logic [TW-1:0]     trig_ts,
    output logic [31:0]       trig_cnt,
    output logic              ovf
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_HOLDOFF} state_t;

    state_t            state;
    logic [NCH*DW-1:0] hist_mem [DEPTH];
    logic [AW-1:0]     wptr, rptr, fill;
    logic [TW-1:0]     ts;
    logic              ext_prev;
    logic [NCH*DW-1:0] prev_data;
    logic [LW-1:0]     rec_len_q, word_cnt, pre_cnt;
    logic [15:0]       holdoff_q, hold_cnt;
    logic              wr_vld_q, sof_q, eof_q;
    logic [NCH*DW-1:0] wr_data_q;
    logic              trig, level_cross, abort;

    // History RAM has no reset; only the pointers do.
    always_ff @(posedge clk) begin
        hist_mem[wptr] <= adc_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            fill      <= '0;
            ts        <= '0;
            ext_prev  <= 1'b0;
            prev_data <= '0;
        end else begin
            wptr      <= wptr + AW'(1);
            if (fill != AW'(DEPTH - 1))
                fill <= fill + AW'(1);
            ts        <= ts + TW'(1);
            ext_prev  <= ext_trig;
            prev_data <= adc_data;
        end
    end

    always_comb begin
        level_cross = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (adc_data[k*DW +: DW] > threshold && prev_data[k*DW +: DW] <= threshold)
                level_cross = 1'b1;
        end
        case (mode)
            2'd0:    trig = trig_pulse;
            2'd1:    trig = ext_trig & ~ext_prev;
            2'd2:    trig = level_cross;
            default: trig = 1'b0;
        endcase
    end

    // Pre-trigger depth is limited by what history exists and by the record length.
    always_comb begin
        pre_cnt = LW'(pre_len);
        if (LW'(fill) < pre_cnt)
            pre_cnt = LW'(fill);
        if (rec_len - LW'(1) < pre_cnt)
            pre_cnt = rec_len - LW'(1);
    end

    assign abort = wr_vld_q & fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rptr      <= '0;
            rec_len_q <= '0;
            word_cnt  <= '0;
            holdoff_q <= '0;
            hold_cnt  <= '0;
            wr_vld_q  <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            wr_data_q <= '0;
            trig_ts   <= '0;
            trig_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            wr_vld_q <= 1'b0;
            if (abort)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm)
                        state <= S_ARMED;
                end
                S_ARMED: begin
                    if (!arm) begin
                        state <= S_IDLE;
                    end else if (trig && rec_len != '0) begin
                        state     <= S_CAPTURE;
                        rec_len_q <= rec_len;
                        holdoff_q <= holdoff;
                        rptr      <= AW'(LW'(wptr) - pre_cnt);
                        word_cnt  <= '0;
                        trig_ts   <= ts;
                        trig_cnt  <= trig_cnt + 32'd1;
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        state    <= S_HOLDOFF;
                        hold_cnt <= 16'd1;
                    end else begin
                        wr_vld_q  <= 1'b1;
                        wr_data_q <= hist_mem[rptr];
                        sof_q     <= (word_cnt == '0);
                        eof_q     <= (word_cnt == rec_len_q - LW'(1));
                        rptr      <= rptr + AW'(1);
                        word_cnt  <= word_cnt + LW'(1);
                        if (word_cnt == rec_len_q - LW'(1)) begin
                            state    <= S_HOLDOFF;
                            hold_cnt <= 16'd1;
                        end
                    end
                end
                S_HOLDOFF: begin
                    // holdoff of 0 still costs one cycle here
                    if (hold_cnt >= holdoff_q)
                        state <= arm ? S_ARMED : S_IDLE;
                    else
                        hold_cnt <= hold_cnt + 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wr_en   = wr_vld_q & ~fifo_full;
    assign wr_sof  = wr_en & sof_q;
    assign wr_eof  = wr_en & eof_q;
    assign wr_data = wr_data_q;
    assign busy    = (state == S_CAPTURE) || (state == S_HOLDOFF);

endmodule
